instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Dual-issue fetch stage feeding the instruction buffer. Holds the PC and reads one aligned
//  64-bit pair per request from instruction memory. Presents up to two instructions with
//  addresses per transfer. Obeys the buffer's stall and redirects the PC on flush.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits[1:0] must be 0
// PORTS
//  clk                 in   1   clock; all state updates on posedge
//  rst                 in   1   synchronous, active-high reset
//  flush               in   1   discard in-flight/presented work, restart at redirect_pc
//  redirect_pc         in   32  new PC, sampled when flush=1; bits[1:0] ignored (treated as 0)
//  stall               in   1   from buffer: 1 = current presentation not accepted this cycle
//  imem_req            out  1   request valid
//  imem_addr           out  32  request address, always 8-byte aligned
//  imem_ready          in   1   memory accepts request when imem_req&&imem_ready
//  imem_rvalid         in   1   response valid; earliest the cycle after acceptance
//  imem_rdata          in   64  [31:0]=word at addr, [63:32]=word at addr+4
//  instructionA/B      out  32  presented instructions, A is program-order older
//  addressA/B          out  32  byte addresses of A/B
//  instructionA_valid  out  1   A valid
//  instructionB_valid  out  1   B valid; never 1 while A_valid=0
// BEHAVIOUR
//  Reset: state=REQ, pc=RESET_PC. All outputs 0 except imem_req=1 and imem_addr=RESET_PC&~7.
//  Transfer rule: presentation accepted on a cycle with A_valid=1 && stall=0.
//  While stall=1, outputs are held bit-stable.
//  FSM, one outstanding request max:
//   REQ  : imem_req=1, imem_addr={pc[31:3],3'b0}. On accept -> WAIT.
//          Addr stays stable until accept.
//   WAIT : on imem_rvalid, load output regs, then -> OUT.
//          pc[2]=0: A=rdata[31:0]@pc, B=rdata[63:32]@pc+4, both valid.
//          pc[2]=1: A=rdata[63:32]@pc, B_valid=0, B/addrB=0.
//          pc <= {pc[31:3],3'b0}+8 (32-bit wrap allowed).
//   OUT  : valids=1. On accept, valids clear next cycle -> REQ.
//   DRAIN: wait for the orphaned imem_rvalid, drop its data, then -> REQ.
//  Latency (zero-wait memory, no stall): req accepted cycle t, rvalid t+1, valids high t+2,
//   next req t+3. Sustained 2 instr / 3 cycles from aligned PC.
//  Flush (priority over stall and rvalid):
//   all states: pc <= redirect_pc&~3; valids 0 next cycle.
//   REQ or OUT -> REQ. imem_req may drop for one cycle, or stay high with a new address;
//    withdrawing an unaccepted request is legal only on flush.
//   WAIT without rvalid that cycle -> DRAIN. WAIT with rvalid that same cycle -> REQ, data dropped.
//   DRAIN -> DRAIN; the response still owed is dropped, and pc is updated again.
//   Flush on the accept cycle in REQ -> DRAIN.
//  rst mid-operation: immediate return to reset state.
//   A response already in flight is the memory's duty to cancel on rst.
//  imem_rvalid outside WAIT/DRAIN is a protocol error (assertion); ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output perf_fetched[31:0] and output perf_flushes[15:0].
//   perf_fetched += A_valid+B_valid on each accepted transfer.
//   perf_flushes += 1 per flush cycle.
//   Both counters wrap and reset to 0.
//  FETCH_PERF_EN undefined: neither port exists and there is no counter logic.
// TESTING
//  1 Reset, RESET_PC=0, imem_ready=1, 1-cycle mem:
//    imem_addr=0; A=mem[0]@0, B=mem[4]@4 at cycle 2; next addr 8 at cycle 3.
//  2 Flush redirect_pc=0x104:
//    imem_addr=0x100; A=word@0x104, B_valid=0; then addr 0x108.
//  3 stall=1 for 5 cycles while OUT:
//    A/B/addr/valid unchanged and no imem_req.
//    After stall drops: one accept, then REQ for pc+8.
//  4 Flush in WAIT, rvalid 3 cycles later:
//    rdata never presented; DRAIN holds until rvalid.
//    Next req addr = redirect_pc&~7.
//  5 Flush in the same cycle as rvalid: data dropped, REQ to redirect next cycle, valids stay 0.
//  6 FETCH_PERF_EN, 3 aligned transfers then 1 flush: perf_fetched=6, perf_flushes=1.
//    pc=0xFFFF_FFF8 fetch: next pc wraps to 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Dual-issue instruction fetch stage.
// Holds the PC, requests one aligned 64-bit pair at a time and presents up to two
// instructions to the instruction buffer. Only one memory request is outstanding at a time.
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched / perf_flushes counters.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [63:0] imem_rdata,
   output logic [31:0] instructionA,
   output logic [31:0] instructionB,
   output logic [31:0] addressA,
   output logic [31:0] addressB,
   output logic        instructionA_valid,
   output logic        instructionB_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [15:0] perf_flushes
`endif
);

   typedef enum logic [1:0] {StReq, StWait, StOut, StDrain} state_e;

   state_e      state_q, state_d;
   // PC is word aligned; only bits [31:2] are stored.
   logic [31:2] pc_q, pc_d;
   logic [31:0] instr_a_q, instr_a_d, instr_b_q, instr_b_d;
   logic [31:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic        valid_a_q, valid_a_d, valid_b_q, valid_b_d;

   // Redirect byte offset is ignored.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Moore outputs straight from state/registers.
   assign imem_req           = (state_q == StReq);
   assign imem_addr          = {pc_q[31:3], 3'b000};
   assign instructionA       = instr_a_q;
   assign instructionB       = instr_b_q;
   assign addressA           = addr_a_q;
   assign addressB           = addr_b_q;
   assign instructionA_valid = valid_a_q;
   assign instructionB_valid = valid_b_q;

   // State and presentation registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StReq;
         pc_q      <= RESET_PC[31:2];
         instr_a_q <= '0;
         instr_b_q <= '0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_a_q <= instr_a_d;
         instr_b_q <= instr_b_d;
         addr_a_q  <= addr_a_d;
         addr_b_q  <= addr_b_d;
         valid_a_q <= valid_a_d;
         valid_b_q <= valid_b_d;
      end
   end

   // Next-state: flush dominates stall and response handling.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_a_d = instr_a_q;
      instr_b_d = instr_b_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      valid_a_d = valid_a_q;
      valid_b_d = valid_b_q;

      if (flush) begin
         pc_d      = redirect_pc[31:2];
         instr_a_d = '0;
         instr_b_d = '0;
         addr_a_d  = '0;
         addr_b_d  = '0;
         valid_a_d = 1'b0;
         valid_b_d = 1'b0;
         case (state_q)
            // An accepted request still owes a response that must be dropped.
            StReq:           state_d = imem_ready ? StDrain : StReq;
            StWait, StDrain: state_d = imem_rvalid ? StReq : StDrain;
            default:         state_d = StReq;
         endcase
      end else begin
         case (state_q)
            StReq: begin
               if (imem_ready) state_d = StWait;
            end
            StWait: begin
               if (imem_rvalid) begin
                  state_d   = StOut;
                  valid_a_d = 1'b1;
                  addr_a_d  = {pc_q, 2'b00};
                  if (!pc_q[2]) begin
                     instr_a_d = imem_rdata[31:0];
                     instr_b_d = imem_rdata[63:32];
                     addr_b_d  = {pc_q[31:3], 3'b100};
                     valid_b_d = 1'b1;
                  end else begin
                     // Entered mid-pair: only the upper word belongs to the stream.
                     instr_a_d = imem_rdata[63:32];
                     instr_b_d = '0;
                     addr_b_d  = '0;
                     valid_b_d = 1'b0;
                  end
                  pc_d = {pc_q[31:3] + 29'd1, 1'b0};
               end
            end
            StOut: begin
               if (!stall) begin
                  state_d   = StReq;
                  instr_a_d = '0;
                  instr_b_d = '0;
                  addr_a_d  = '0;
                  addr_b_d  = '0;
                  valid_a_d = 1'b0;
                  valid_b_d = 1'b0;
               end
            end
            default: begin
               if (imem_rvalid) state_d = StReq;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [15:0] perf_flushes_q;

   // Counts instructions handed over and flush cycles; both wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_flushes_q <= '0;
      end else begin
         if (valid_a_q && !stall) perf_fetched_q <= perf_fetched_q + (valid_b_q ? 32'd2 : 32'd1);
         if (flush) perf_flushes_q <= perf_flushes_q + 16'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushes = perf_flushes_q;
`endif

   // A response may only arrive while one is owed.
   rvalid_owed_a: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (state_q == StWait || state_q == StDrain));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized run checked
// against a stream-level reference model (next expected fetch PC and memory contents).
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [63:0] imem_rdata = '0;
   logic [31:0] instructionA, instructionB, addressA, addressB;
   logic        instructionA_valid, instructionB_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [15:0] perf_flushes;
`endif

   int checks = 0;
   int failures = 0;

   // Memory model: one outstanding response with a countdown.
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int unsigned pend_cnt = 0;

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .redirect_pc        (redirect_pc),
      .stall              (stall),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ready         (imem_ready),
      .imem_rvalid        (imem_rvalid),
      .imem_rdata         (imem_rdata),
      .instructionA       (instructionA),
      .instructionB       (instructionB),
      .addressA           (addressA),
      .addressB           (addressB),
      .instructionA_valid (instructionA_valid),
      .instructionB_valid (instructionB_valid)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched       (perf_fetched),
      .perf_flushes       (perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1357_2468;
   endfunction

   function automatic logic [129:0] snap();
      return {instructionA, instructionB, addressA, addressB,
              instructionA_valid, instructionB_valid};
   endfunction

   // Drive inputs for the coming edge, run the memory model, advance to edge + 1.
   task automatic cycle(input bit fl, input logic [31:0] rpc, input bit st, input bit rdy,
                        input int unsigned lat);
      flush       = fl;
      redirect_pc = rpc;
      stall       = st;
      imem_ready  = rdy;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = {mem_word(pend_addr + 32'd4), mem_word(pend_addr)};
            pend        = 1'b0;
         end else begin
            pend_cnt = pend_cnt - 1;
         end
      end
      if (imem_req && rdy && !rst) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = lat - 1;
      end
      if (rst) pend = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(0, '0, 0, 0, 1);
      cycle(0, '0, 0, 0, 1);
      rst = 1'b0;
      checks++;
      if (imem_req !== 1'b1) begin
         failures++; $display("FAIL reset_req got=%b exp=1", imem_req);
      end
      checks++;
      if (imem_addr !== (RESET_PC & ~32'd7)) begin
         failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC & ~32'd7);
      end
      checks++;
      if (snap() !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", snap());
      end
`ifdef FETCH_PERF_EN
      checks++;
      if ({perf_fetched, perf_flushes} !== '0) begin
         failures++; $display("FAIL reset_perf got=%h/%h exp=0", perf_fetched, perf_flushes);
      end
`endif
      cycle(0, '0, 0, 1, 1);  // request for 0 accepted
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL wait_no_req got=%b exp=0", imem_req);
      end
      cycle(0, '0, 0, 1, 1);  // response arrives
      checks++;
      if ({instructionA_valid, instructionB_valid, instructionA, addressA, instructionB, addressB}
          !== {2'b11, mem_word(0), 32'd0, mem_word(4), 32'd4}) begin
         failures++;
         $display("FAIL first_pair got=%h/%h %h/%h v=%b%b exp=%h/0 %h/4 v=11", instructionA,
                  addressA, instructionB, addressB, instructionA_valid, instructionB_valid,
                  mem_word(0), mem_word(4));
      end
      cycle(0, '0, 0, 1, 1);  // transfer accepted
      checks++;
      if ({imem_req, imem_addr, instructionA_valid, instructionB_valid} !== {1'b1, 32'd8, 2'b00})
      begin
         failures++; $display("FAIL next_req got=%b/%h v=%b exp=1/8 v=0", imem_req, imem_addr,
                              instructionA_valid);
      end
   endtask

   task automatic test_flush_unaligned();
      cycle(1, 32'h104, 0, 0, 1);
      checks++;
      if ({imem_req, imem_addr, instructionA_valid} !== {1'b1, 32'h100, 1'b0}) begin
         failures++; $display("FAIL flush_req got=%b/%h exp=1/100", imem_req, imem_addr);
      end
      cycle(0, '0, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({instructionA_valid, instructionB_valid, instructionA, addressA, instructionB, addressB}
          !== {2'b10, mem_word(32'h104), 32'h104, 64'd0}) begin
         failures++; $display("FAIL unaligned_pair got=%h/%h %h/%h v=%b%b exp=%h/104 0/0 v=10",
                              instructionA, addressA, instructionB, addressB, instructionA_valid,
                              instructionB_valid, mem_word(32'h104));
      end
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin
         failures++; $display("FAIL after_unaligned got=%b/%h exp=1/108", imem_req, imem_addr);
      end
   endtask

   task automatic test_stall();
      logic [129:0] held;
      cycle(0, '0, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      held = snap();
      checks++;
      if (held !== {mem_word(32'h108), mem_word(32'h10C), 32'h108, 32'h10C, 2'b11}) begin
         failures++; $display("FAIL stall_pair got=%h", held);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(0, '0, 1, 1, 1);
         checks++;
         if ({snap(), imem_req} !== {held, 1'b0}) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/0", i, snap(),
                                 imem_req, held);
         end
      end
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({imem_req, imem_addr, instructionA_valid} !== {1'b1, 32'h110, 1'b0}) begin
         failures++; $display("FAIL stall_release got=%b/%h v=%b exp=1/110 v=0", imem_req,
                              imem_addr, instructionA_valid);
      end
   endtask

   task automatic test_flush_wait();
      cycle(0, '0, 0, 1, 4);  // accept 0x110, response 4 cycles later
      cycle(1, 32'h20C, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_req, instructionA_valid} !== 2'b00) begin
            failures++; $display("FAIL drain_hold cyc=%0d got=%b%b exp=00", i, imem_req,
                                 instructionA_valid);
         end
         cycle(0, '0, 0, 0, 1);
      end
      checks++;
      if ({imem_req, imem_addr, instructionA_valid} !== {1'b1, 32'h208, 1'b0}) begin
         failures++; $display("FAIL drain_exit got=%b/%h v=%b exp=1/208 v=0", imem_req, imem_addr,
                              instructionA_valid);
      end
      cycle(0, '0, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({instructionA_valid, instructionB_valid, instructionA, addressA}
          !== {2'b10, mem_word(32'h20C), 32'h20C}) begin
         failures++; $display("FAIL redirect_pair got=%h/%h v=%b%b exp=%h/20c v=10", instructionA,
                              addressA, instructionA_valid, instructionB_valid,
                              mem_word(32'h20C));
      end
      cycle(0, '0, 0, 1, 1);
   endtask

   task automatic test_flush_rvalid();
      cycle(0, '0, 0, 1, 1);  // accept 0x210
      cycle(1, 32'h300, 0, 0, 1);  // response lands in the flush cycle
      checks++;
      if ({imem_req, imem_addr, instructionA_valid} !== {1'b1, 32'h300, 1'b0}) begin
         failures++; $display("FAIL flush_rvalid got=%b/%h v=%b exp=1/300 v=0", imem_req,
                              imem_addr, instructionA_valid);
      end
      cycle(0, '0, 0, 0, 1);
      checks++;
      if ({imem_req, instructionA_valid, instructionB_valid} !== 3'b100) begin
         failures++; $display("FAIL flush_rvalid_quiet got=%b%b%b exp=100", imem_req,
                              instructionA_valid, instructionB_valid);
      end
      cycle(0, '0, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({instructionA, addressA, instructionB, addressB}
          !== {mem_word(32'h300), 32'h300, mem_word(32'h304), 32'h304}) begin
         failures++; $display("FAIL flush_rvalid_pair got=%h/%h %h/%h", instructionA, addressA,
                              instructionB, addressB);
      end
      cycle(0, '0, 0, 1, 1);
   endtask

   task automatic test_perf_wrap();
      rst = 1'b1;
      cycle(0, '0, 0, 0, 1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, '0, 0, 1, 1);
         cycle(0, '0, 0, 1, 1);
         cycle(0, '0, 0, 1, 1);
      end
      cycle(1, 32'hFFFF_FFF8, 0, 0, 1);
`ifdef FETCH_PERF_EN
      checks++;
      if ({perf_fetched, perf_flushes} !== {32'd6, 16'd1}) begin
         failures++; $display("FAIL perf_counts got=%0d/%0d exp=6/1", perf_fetched, perf_flushes);
      end
`endif
      checks++;
      if (imem_addr !== 32'hFFFF_FFF8) begin
         failures++; $display("FAIL wrap_req got=%h exp=fffffff8", imem_addr);
      end
      cycle(0, '0, 0, 1, 1);
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({addressA, addressB, instructionA, instructionB} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC,
          mem_word(32'hFFFF_FFF8), mem_word(32'hFFFF_FFFC)}) begin
         failures++; $display("FAIL wrap_pair got=%h/%h", addressA, addressB);
      end
      cycle(0, '0, 0, 1, 1);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
         failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0]  exp_pc;
      logic [31:0]  exp_fetched;
      logic [15:0]  exp_flushes;
      logic [129:0] prev;
      bit           prev_hold, prev_flush;
      int           transfers;
      rst = 1'b1;
      cycle(0, '0, 0, 0, 1);
      rst = 1'b0;
      exp_pc = RESET_PC; exp_fetched = '0; exp_flushes = '0;
      prev = '0; prev_hold = 1'b0; prev_flush = 1'b0; transfers = 0;
      for (int n = 0; n < 3000; n++) begin
         bit          fl, st, rdy, do_rst;
         logic [31:0] rpc, b_exp_addr;
         int unsigned lat;
         checks++;
         if (imem_addr[2:0] !== 3'b000) begin
            failures++; $display("FAIL rnd_align n=%0d got=%h", n, imem_addr);
         end
         checks++;
         if (instructionB_valid && !instructionA_valid) begin
            failures++; $display("FAIL rnd_b_without_a n=%0d got=01 exp=not 01", n);
         end
         if (prev_flush) begin
            checks++;
            if (instructionA_valid !== 1'b0) begin
               failures++; $display("FAIL rnd_flush_valid n=%0d got=%b exp=0", n,
                                    instructionA_valid);
            end
         end
         if (prev_hold) begin
            checks++;
            if (snap() !== prev) begin
               failures++; $display("FAIL rnd_stall_hold n=%0d got=%h exp=%h", n, snap(), prev);
            end
         end
         if (instructionA_valid) begin
            checks++;
            if (imem_req !== 1'b0) begin
               failures++; $display("FAIL rnd_req_while_out n=%0d got=1 exp=0", n);
            end
         end
         do_rst = ($urandom_range(0, 299) == 0);
         fl     = ($urandom_range(0, 15) == 0);
         st     = ($urandom_range(0, 2) == 0);
         rdy    = ($urandom_range(0, 2) != 0);
         lat    = $urandom_range(1, 4);
         rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         if (do_rst) begin
            rst = 1'b1;
            exp_pc = RESET_PC; exp_fetched = '0; exp_flushes = '0;
            prev_hold = 1'b0; prev_flush = 1'b1;
         end else begin
            rst = 1'b0;
            if (instructionA_valid && !st) begin
               b_exp_addr = exp_pc + 32'd4;
               checks++;
               if ({addressA, instructionA} !== {exp_pc, mem_word(exp_pc)}) begin
                  failures++; $display("FAIL rnd_slot_a n=%0d got=%h/%h exp=%h/%h", n, addressA,
                                       instructionA, exp_pc, mem_word(exp_pc));
               end
               checks++;
               if (!exp_pc[2]) begin
                  if ({instructionB_valid, addressB, instructionB}
                      !== {1'b1, b_exp_addr, mem_word(b_exp_addr)}) begin
                     failures++; $display("FAIL rnd_slot_b n=%0d got=%b %h/%h exp=1 %h/%h", n,
                                          instructionB_valid, addressB, instructionB, b_exp_addr,
                                          mem_word(b_exp_addr));
                  end
               end else if ({instructionB_valid, addressB, instructionB} !== '0) begin
                  failures++; $display("FAIL rnd_slot_b n=%0d got=%b %h/%h exp=0 0/0", n,
                                       instructionB_valid, addressB, instructionB);
               end
               exp_fetched = exp_fetched + (exp_pc[2] ? 32'd1 : 32'd2);
               exp_pc = {exp_pc[31:3], 3'b000} + 32'd8;
               transfers++;
            end
            if (imem_req && rdy && !fl) begin
               checks++;
               if (imem_addr !== {exp_pc[31:3], 3'b000}) begin
                  failures++; $display("FAIL rnd_req_addr n=%0d got=%h exp=%h", n, imem_addr,
                                       {exp_pc[31:3], 3'b000});
               end
            end
            if (fl) begin
               exp_pc = rpc & ~32'd3;
               exp_flushes = exp_flushes + 16'd1;
            end
            prev_hold  = instructionA_valid && st && !fl;
            prev_flush = fl;
            prev       = snap();
         end
         cycle(fl, rpc, st, rdy, lat);
      end
      rst = 1'b0;
      checks++;
      if (transfers < 100) begin
         failures++; $display("FAIL rnd_progress got=%0d exp>=100", transfers);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if ({perf_fetched, perf_flushes} !== {exp_fetched, exp_flushes}) begin
         failures++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", perf_fetched,
                              perf_flushes, exp_fetched, exp_flushes);
      end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_flush_unaligned();
      test_stall();
      test_flush_wait();
      test_flush_rvalid();
      test_perf_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
